// File: rtl/wb_arbiter2_if.sv
// ---------------------------------------------------------------------------
// wishbone -- classic Wishbone bus bundle used by wb_arbiter2.
//
// Signal names are from the bus master's point of view:
//   cyc, stb, we, sel, adr, dat_o : master -> slave
//   dat_i, ack, err, rty          : slave  -> master
//
// Modports:
//   master : the side that starts cycles (drives cyc/stb/...)
//   slave  : the side that answers cycles (drives ack/err/rty/dat_i)
//
// Parameters:
//   AW : address width
//   DW : data width (sel is DW/8 bits)
// ---------------------------------------------------------------------------
interface wishbone #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic              cyc;
    logic              stb;
    logic              we;
    logic [DW/8-1:0]   sel;
    logic [AW-1:0]     adr;
    logic [DW-1:0]     dat_o;
    logic [DW-1:0]     dat_i;
    logic              ack;
    logic              err;
    logic              rty;

    modport master (
        output cyc, stb, we, sel, adr, dat_o,
        input  dat_i, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack, err, rty
    );
endinterface

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2 -- two-master round-robin Wishbone arbiter.
//
// A master requests the shared bus by raising cyc. From IDLE a single
// requester is granted on the next edge; a tie goes to the master that was
// NOT granted last. The grant is held for as long as the owner keeps cyc
// high (bus lock, no preemption). When the owner drops cyc the bus passes
// straight to the other master if it is waiting, otherwise back to IDLE.
// The data path is purely combinational: the owner's request signals go to
// the shared bus and the bus responses go back to the owner only.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   m0   : wishbone.slave  -- requester 0 (e.g. CPU data master)
//   m1   : wishbone.slave  -- requester 1 (e.g. DMA/JPEG master)
//   s    : wishbone.master -- shared bus towards the slaves
//   gnt  : one-hot grant status {m1 owns, m0 owns}; 00 = idle
//
// Parameters:
//   TO_CYCLES : bus-timeout limit in cycles (2..255), used only with the
//               optional timeout feature.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   An 8-bit stall counter runs while the owner strobes and the slave gives
//   no response. When it reaches TO_CYCLES-1 the owner gets a one-cycle err,
//   s.stb is suppressed for that cycle and the counter restarts. The grant
//   itself is still only released when the owner drops cyc. Without the
//   macro no counter exists and a stalled slave stalls the owner forever.
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    wishbone.slave      m0,
    wishbone.slave      m1,
    wishbone.master     s,
    output logic [1:0]  gnt
);

    // Out-of-range limits would make the 8-bit compare silently wrong.
    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to_cycles
        $error("wb_arbiter2: TO_CYCLES must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e state_q;
    logic   last_q;     // most recently granted master (0 or 1)

    logic   req0;
    logic   req1;
    logic   sel0;
    logic   sel1;
    logic   own_cyc;
    logic   own_stb;
    logic   to_fire;    // timeout error pulse for the current owner

    assign req0 = m0.cyc;
    assign req1 = m1.cyc;

    assign sel0 = (state_q == GNT0);
    assign sel1 = (state_q == GNT1);

    // Grant status is a pure decode of the state register.
    assign gnt = {sel1, sel0};

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // m0 wins the first tie after reset
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= GNT0;
                        last_q  <= 1'b0;
                    end else if (req1) begin
                        state_q <= GNT1;
                        last_q  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!req0) begin
                        if (req1) begin
                            state_q <= GNT1;    // direct hand-over, no idle gap
                            last_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!req1) begin
                        if (req0) begin
                            state_q <= GNT0;
                            last_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Request path: owner -> shared bus. IDLE drives an all-zero bus.
    // -----------------------------------------------------------------------
    assign own_cyc = sel0 ? m0.cyc : (sel1 ? m1.cyc : 1'b0);
    assign own_stb = sel0 ? m0.stb : (sel1 ? m1.stb : 1'b0);

    assign s.cyc   = own_cyc;
    assign s.stb   = own_stb & ~to_fire;    // strobe withheld on a timeout
    assign s.we    = sel0 ? m0.we    : (sel1 ? m1.we    : 1'b0);
    assign s.sel   = sel0 ? m0.sel   : (sel1 ? m1.sel   : '0);
    assign s.adr   = sel0 ? m0.adr   : (sel1 ? m1.adr   : '0);
    assign s.dat_o = sel0 ? m0.dat_o : (sel1 ? m1.dat_o : '0);

    // -----------------------------------------------------------------------
    // Response path: shared bus -> owner only. Read data is broadcast since
    // it is qualified by ack anyway.
    // -----------------------------------------------------------------------
    assign m0.ack   = sel0 & s.ack;
    assign m0.err   = sel0 & (s.err | to_fire);
    assign m0.rty   = sel0 & s.rty;
    assign m0.dat_i = s.dat_i;

    assign m1.ack   = sel1 & s.ack;
    assign m1.err   = sel1 & (s.err | to_fire);
    assign m1.rty   = sel1 & s.rty;
    assign m1.dat_i = s.dat_i;

    // -----------------------------------------------------------------------
    // Optional bus timeout
    // -----------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] to_cnt_q;
    logic [7:0] to_cnt_d;

    // Fires from the registered count, so there is no path from s.ack.
    assign to_fire = (sel0 | sel1) && (to_cnt_q == TO_LAST);

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        to_cnt_d = to_cnt_q;
        // Any slave response, the timeout itself, or the owner releasing
        // the bus restarts the stall count; a wait with stb low just holds.
        if (!(sel0 | sel1) || !own_cyc || s.ack || s.err || s.rty || to_fire) begin
            to_cnt_d = '0;
        end else if (own_stb) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2 -- self-checking bench for wb_arbiter2.
//
// A behavioural model tracks who owns the bus (0 = nobody, 1 = m0, 2 = m1),
// which master was granted last and, with WB_ARB_TIMEOUT_EN, how long the
// owner has been stalled. All DUT outputs are compared with the model after
// every step; directed steps add fixed expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;

    wishbone m0_if ();
    wishbone m1_if ();
    wishbone s_if  ();

    wb_arbiter2 #(.TO_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if.slave),
        .m1  (m1_if.slave),
        .s   (s_if.master),
        .gnt (gnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int owner;      // 0 = idle, 1 = m0, 2 = m1
    int last_m;     // last granted master index (0/1)
    int stall;      // stall cycles seen by the owner

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fire_now();
`ifdef WB_ARB_TIMEOUT_EN
        return (owner != 0) && (stall == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        owner  = 0;
        last_m = 1;
        stall  = 0;
    endfunction

    // Called exactly at a rising edge, before any input changes.
    function automatic void model_edge();
        logic c0, c1, own_c, own_s, f;
        int   prev;
        c0    = m0_if.cyc;
        c1    = m1_if.cyc;
        f     = fire_now();
        own_c = (owner == 1) ? c0 : ((owner == 2) ? c1 : 1'b0);
        own_s = (owner == 1) ? m0_if.stb : ((owner == 2) ? m1_if.stb : 1'b0);
        if (owner == 0 || !own_c || s_if.ack || s_if.err || s_if.rty || f)
            stall = 0;
        else if (own_s)
            stall = stall + 1;
        prev = owner;
        if (owner == 0) begin
            if (c0 && c1)  owner = 2 - last_m;   // the one not granted last
            else if (c0)   owner = 1;
            else if (c1)   owner = 2;
        end else if (!own_c) begin
            if ((owner == 1) ? c1 : c0) owner = 3 - owner;
            else                        owner = 0;
        end
        if (owner != 0 && owner != prev) last_m = owner - 1;
    endfunction

    task automatic check_all(input string tag);
        logic        f, e_cyc, e_stb, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_dat;
        logic [1:0]  e_gnt;
        f = fire_now();
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_sel = '0; e_adr = '0; e_dat = '0; e_gnt = 2'b00;
        if (owner == 1) begin
            e_cyc = m0_if.cyc; e_stb = m0_if.stb; e_we = m0_if.we;
            e_sel = m0_if.sel; e_adr = m0_if.adr; e_dat = m0_if.dat_o;
            e_gnt = 2'b01;
        end else if (owner == 2) begin
            e_cyc = m1_if.cyc; e_stb = m1_if.stb; e_we = m1_if.we;
            e_sel = m1_if.sel; e_adr = m1_if.adr; e_dat = m1_if.dat_o;
            e_gnt = 2'b10;
        end
        e_stb = e_stb & ~f;
        chk({tag, ".gnt"},     64'(gnt),         64'(e_gnt));
        chk({tag, ".s_cyc"},   64'(s_if.cyc),    64'(e_cyc));
        chk({tag, ".s_stb"},   64'(s_if.stb),    64'(e_stb));
        chk({tag, ".s_we"},    64'(s_if.we),     64'(e_we));
        chk({tag, ".s_sel"},   64'(s_if.sel),    64'(e_sel));
        chk({tag, ".s_adr"},   64'(s_if.adr),    64'(e_adr));
        chk({tag, ".s_dat"},   64'(s_if.dat_o),  64'(e_dat));
        chk({tag, ".m0_ack"},  64'(m0_if.ack),   64'((owner == 1) & s_if.ack));
        chk({tag, ".m0_err"},  64'(m0_if.err),   64'((owner == 1) & (s_if.err | f)));
        chk({tag, ".m0_rty"},  64'(m0_if.rty),   64'((owner == 1) & s_if.rty));
        chk({tag, ".m0_dat"},  64'(m0_if.dat_i), 64'(s_if.dat_i));
        chk({tag, ".m1_ack"},  64'(m1_if.ack),   64'((owner == 2) & s_if.ack));
        chk({tag, ".m1_err"},  64'(m1_if.err),   64'((owner == 2) & (s_if.err | f)));
        chk({tag, ".m1_rty"},  64'(m1_if.rty),   64'((owner == 2) & s_if.rty));
        chk({tag, ".m1_dat"},  64'(m1_if.dat_i), 64'(s_if.dat_i));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input string tag);
        #1;
        check_all(tag);
    endtask

    task automatic drive_m0(input logic c, input logic st, input logic w);
        m0_if.cyc = c; m0_if.stb = st; m0_if.we = w;
        m0_if.adr = $urandom; m0_if.dat_o = $urandom; m0_if.sel = 4'($urandom);
    endtask

    task automatic drive_m1(input logic c, input logic st, input logic w);
        m1_if.cyc = c; m1_if.stb = st; m1_if.we = w;
        m1_if.adr = $urandom; m1_if.dat_o = $urandom; m1_if.sel = 4'($urandom);
    endtask

    task automatic slave_resp(input logic a, input logic e, input logic r);
        s_if.ack = a; s_if.err = e; s_if.rty = r; s_if.dat_i = $urandom;
    endtask

    int acks;
    int err_first;
    int err_cnt;
    logic err_after;

    initial begin
        drive_m0(0, 0, 0);
        drive_m1(0, 0, 0);
        slave_resp(0, 0, 0);
        model_reset();

        // Reset state
        #1;
        check_all("reset");
        chk("reset.gnt00", 64'(gnt), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests after reset: m0 wins, then direct hand-over
        drive_m0(1, 1, 0);
        drive_m1(1, 1, 1);
        settle("tie.idle");
        cycle();
        settle("tie.grant");
        chk("tie.gnt01", 64'(gnt), 64'(2'b01));
        drive_m0(0, 0, 0);
        settle("tie.drop");
        cycle();
        settle("handoff");
        chk("handoff.gnt10", 64'(gnt), 64'(2'b10));
        drive_m1(0, 0, 0);
        cycle();
        settle("idle1");
        chk("idle1.gnt00", 64'(gnt), 64'(0));

        // m1 alone, 4-beat locked write burst with ack every cycle
        drive_m1(1, 1, 1);
        cycle();
        settle("burst.grant");
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            slave_resp(1, 0, 0);
            drive_m1(1, 1, 1);
            settle("burst.beat");
            if (m1_if.ack === 1'b1) acks++;
            chk("burst.m0_ack0", 64'(m0_if.ack), 64'(0));
            chk("burst.gnt10", 64'(gnt), 64'(2'b10));
            cycle();
        end
        slave_resp(0, 0, 0);
        drive_m1(0, 0, 0);
        settle("burst.end");
        chk("burst.acks4", 64'(acks), 64'(4));
        cycle();
        settle("idle2");

        // Both request continuously: grants alternate 01,10,01,10
        drive_m0(1, 1, 0);
        drive_m1(1, 1, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            settle("rr.grant");
            chk("rr.gnt_alt", 64'(gnt), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            slave_resp(1, 0, 0);
            settle("rr.ack");
            cycle();
            slave_resp(0, 0, 0);
            if (i % 2 == 0) drive_m0(0, 0, 0); else drive_m1(0, 0, 0);
            settle("rr.drop");
            cycle();
            if (i % 2 == 0) drive_m0(1, 1, 0); else drive_m1(1, 1, 0);
        end
        drive_m0(0, 0, 0);
        drive_m1(0, 0, 0);
        settle("rr.end");
        cycle();
        settle("idle3");

        // m0 single-cycle transfer, ack in the same cycle
        drive_m0(1, 1, 0);
        cycle();
        settle("single.grant");
        slave_resp(1, 0, 0);
        settle("single.ack");
        chk("single.m0_ack1", 64'(m0_if.ack), 64'(1));
        drive_m0(0, 0, 0);
        slave_resp(0, 0, 0);
        cycle();
        settle("single.idle");
        chk("single.gnt00", 64'(gnt), 64'(0));

        // Reset pulse while m1 is mid-transfer with a stalled slave
        drive_m1(1, 1, 1);
        cycle();
        settle("rstmid.grant");
        chk("rstmid.gnt10", 64'(gnt), 64'(2'b10));
        cycle();
        settle("rstmid.stall");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rstmid.inrst");
        chk("rstmid.s_cyc0", 64'(s_if.cyc), 64'(0));
        #1;
        rst = 1'b0;
        drive_m0(1, 1, 0);
        settle("rstmid.tie");
        cycle();
        settle("rstmid.after");
        chk("rstmid.gnt01", 64'(gnt), 64'(2'b01));
        drive_m0(0, 0, 0);
        drive_m1(0, 0, 0);
        cycle();
        settle("idle4");

        // Slave never answers m0
        drive_m0(1, 1, 0);
        err_first = -1;
        err_cnt   = 0;
        err_after = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            cycle();
            settle("to.wait");
            if (m0_if.err === 1'b1) begin
                if (err_first < 0) err_first = k;
                if (k == 17) err_after = 1'b1;
            end
        end
        chk("to.latency16", 64'(err_first), 64'(16));
        chk("to.one_cycle", 64'(err_after), 64'(0));
`else
        for (int k = 1; k <= 1000; k++) begin
            cycle();
            settle("noto.wait");
            if (m0_if.err === 1'b1) err_cnt++;
        end
        chk("noto.no_err", 64'(err_cnt), 64'(0));
`endif
        drive_m0(0, 0, 0);
        cycle();
        settle("idle5");

        // Randomised traffic against the model
        for (int k = 0; k < 500; k++) begin
            int r;
            logic c;
            cycle();
            c = m0_if.cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            drive_m0(c, c & 1'($urandom), 1'($urandom));
            c = m1_if.cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            drive_m1(c, c & 1'($urandom), 1'($urandom));
            r = $urandom_range(0, 7);
            slave_resp(r < 3, r == 3, r == 4);
            settle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
